// File: rtl/mux_scan_sequencer_if.sv
// Word-in / bit-out handshake bundle for the 16:1 mux scan sequencer.
// The word and s signals also drive an external 16:1 mux.
interface mux_scan_sequencer_if;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] word;
  logic [3:0]  s;
  logic        ser_bit;
  logic        ser_valid;
  logic        ser_last;
  logic        ser_ready;

  modport slave (
    input  in_data, in_valid, ser_ready,
    output in_ready, word, s, ser_bit, ser_valid, ser_last
  );

  modport master (
    output in_data, in_valid, ser_ready,
    input  in_ready, word, s, ser_bit, ser_valid, ser_last
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Holds a 16-bit word and steps a 4-bit select so that an external 16:1 mux
// serialises it one bit per transfer; select k picks word bit 15-k.
module mux_scan_sequencer #(
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  mux_scan_sequencer_if.slave  bus
);
  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [3:0] S_START = (MSB_FIRST != 0) ? 4'd0  : 4'd15;
  localparam logic [3:0] S_END   = (MSB_FIRST != 0) ? 4'd15 : 4'd0;

  state_t      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [3:0]  s_q, s_d;
  logic        last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= 16'h0000;
      s_q     <= S_START;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      s_q     <= s_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    s_d     = s_q;
    last    = (state_q == SCAN) && (s_q == S_END);
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          word_d  = bus.in_data;
          s_d     = S_START;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (bus.ser_ready) begin
          if (last) begin
            // back-to-back reload keeps the bit stream gapless
            if (bus.in_valid) begin
              word_d = bus.in_data;
              s_d    = S_START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = (MSB_FIRST != 0) ? s_q + 4'd1 : s_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.word      = word_q;
  assign bus.s         = s_q;
  assign bus.ser_bit   = word_q[4'd15 - s_q];
  assign bus.ser_valid = (state_q == SCAN);
  assign bus.ser_last  = last;
  assign bus.in_ready  = (state_q == IDLE) || (last && bus.ser_ready);
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench: one MSB-first and one LSB-first sequencer share stimulus,
// each feeding a 16:1 mux whose output is compared with ser_bit.
module tb_mux_scan_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        ser_ready;
  logic        mux0, mux1;
  logic [15:0] b0, b1, w;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  mux_scan_sequencer_if i0();
  mux_scan_sequencer_if i1();

  assign i0.in_data = in_data;
  assign i0.in_valid = in_valid;
  assign i0.ser_ready = ser_ready;
  assign i1.in_data = in_data;
  assign i1.in_valid = in_valid;
  assign i1.ser_ready = ser_ready;

  // board-level 16:1 muxes: select k routes data bit 15-k
  assign mux0 = i0.word[4'd15 - i0.s];
  assign mux1 = i1.word[4'd15 - i1.s];

  mux_scan_sequencer #(.MSB_FIRST(1)) u_msb (.clk(clk), .rst(rst), .bus(i0));
  mux_scan_sequencer #(.MSB_FIRST(0)) u_lsb (.clk(clk), .rst(rst), .bus(i1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // position k of a word in flight, both bit orders
  task automatic pos(input string tag, input logic [15:0] wd, input int k);
    chk({tag, "_v0"}, i0.ser_valid, 1'b1);
    chk({tag, "_s0"}, i0.s, k);
    chk({tag, "_b0"}, i0.ser_bit, wd[15-k]);
    chk({tag, "_l0"}, i0.ser_last, k == 15);
    chk({tag, "_m0"}, mux0, i0.ser_bit);
    chk({tag, "_v1"}, i1.ser_valid, 1'b1);
    chk({tag, "_s1"}, i1.s, 15 - k);
    chk({tag, "_b1"}, i1.ser_bit, wd[k]);
    chk({tag, "_l1"}, i1.ser_last, k == 15);
    chk({tag, "_m1"}, mux1, i1.ser_bit);
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_v0"}, i0.ser_valid, 1'b0);
    chk({tag, "_v1"}, i1.ser_valid, 1'b0);
    chk({tag, "_r0"}, i0.in_ready, 1'b1);
    chk({tag, "_r1"}, i1.in_ready, 1'b1);
    chk({tag, "_l0"}, i0.ser_last, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 16'hDEAD; ser_ready = 1'b1;
    tick; tick;
    idle_chk("rst");
    chk("rst_w0", i0.word, 16'h0000);
    chk("rst_s0", i0.s, 4'd0);
    chk("rst_s1", i1.s, 4'd15);

    // first word accepted on the first edge with rst low
    rst = 1'b0; in_data = 16'h300E; in_valid = 1'b1;
    tick;
    in_valid = 1'b0; in_data = 16'h5555;
    b0 = 16'b0011_0000_0000_1110;
    b1 = 16'b0111_0000_0000_1100;
    for (int k = 0; k < 16; k++) begin
      chk("seq_msb", i0.ser_bit, b0[15-k]);
      chk("seq_lsb", i1.ser_bit, b1[15-k]);
      pos("w300e", 16'h300E, k);
      chk("w300e_rdy", i0.in_ready, k == 15);
      tick;
    end
    idle_chk("idle1");
    chk("hold_w0", i0.word, 16'h300E);
    chk("hold_s0", i0.s, 4'd15);
    chk("hold_s1", i1.s, 4'd0);

    // back-to-back words, no bubble
    in_data = 16'hA5A5; in_valid = 1'b1;
    tick;
    in_data = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      w = (i < 16) ? 16'hA5A5 : 16'hFFFF;
      pos("b2b", w, i % 16);
      chk("b2b_rdy0", i0.in_ready, (i % 16) == 15);
      chk("b2b_rdy1", i1.in_ready, (i % 16) == 15);
      if (i == 30) in_valid = 1'b0;
      tick;
    end
    idle_chk("idle2");

    // stall at s=5 for three cycles; a word offered meanwhile is refused
    in_data = 16'h1234; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pos("pre", 16'h1234, k);
      tick;
    end
    ser_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0F0F;
    for (int j = 0; j < 3; j++) begin
      pos("stall", 16'h1234, 5);
      chk("stall_rdy", i0.in_ready, 1'b0);
      tick;
    end
    ser_ready = 1'b1; in_valid = 1'b0;
    for (int k = 5; k < 16; k++) begin
      pos("post", 16'h1234, k);
      tick;
    end
    idle_chk("idle3");
    chk("stall_w0", i0.word, 16'h1234);

    // reset mid-word at s=8 beats a pending handshake
    in_data = 16'hBEEF; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      pos("pre_rst", 16'hBEEF, k);
      tick;
    end
    chk("at8_s0", i0.s, 4'd8);
    rst = 1'b1; in_valid = 1'b1; in_data = 16'h1111;
    tick;
    rst = 1'b0; in_valid = 1'b0;
    idle_chk("mrst");
    chk("mrst_s0", i0.s, 4'd0);
    chk("mrst_s1", i1.s, 4'd15);
    chk("mrst_w0", i0.word, 16'h0000);
    chk("mrst_w1", i1.word, 16'h0000);
    in_data = 16'h8001; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      pos("w8001", 16'h8001, k);
      tick;
    end
    idle_chk("idle4");

    // random words: mux output must track ser_bit
    for (int n = 0; n < 4; n++) begin
      w = 16'($urandom);
      in_data = w; in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
        pos("rnd", w, k);
        tick;
      end
      idle_chk("idle_rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_scan_sequencer.md
MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 Parameter: MSB_FIRST, default 1, bit order; 1 = word bit 15 first, 0 = word bit 0 first.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock, sole clock domain.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: in_data  input  16  parallel word to scan.
REQ-006 Port: in_valid  input  1  in_data valid.
REQ-007 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-008 Port: word  output  16  held word; drives the 16:1 mux data input.
REQ-009 Port: s  output  4  select; drives the 16:1 mux select input.
REQ-010 Port: ser_bit  output  1  local copy of the selected bit, word[15 - s].
REQ-011 Port: ser_valid  output  1  ser_bit and mux output valid this cycle.
REQ-012 Port: ser_last  output  1  current bit is the 16th of the word.
REQ-013 Port: ser_ready  input  1  downstream consumes the current bit.

Function
REQ-014 The block SHALL drive the 16:1 mux with this mapping: select value k yields word bit 15-k.
REQ-015 The block SHALL implement two states, IDLE and SCAN.
REQ-016 IDLE: in_ready=1 and ser_valid=0.
REQ-017 IDLE, in_valid=1 at the edge: word<=in_data; s<=start value; go to SCAN.
REQ-018 Start value SHALL be 0 when MSB_FIRST=1 and 15 when MSB_FIRST=0.
REQ-019 SCAN: ser_valid=1; ser_bit=word[15-s], combinational from registered word and s.
REQ-020 A bit transfer SHALL occur on an edge with ser_valid=1 and ser_ready=1.
REQ-021 With ser_ready=0, word, s and all outputs SHALL hold unchanged (stall, no bit lost or repeated).
REQ-022 On a non-last transfer, s SHALL step +1 (MSB_FIRST=1) or -1 (MSB_FIRST=0), with no wrap mid-word.
REQ-023 ser_last SHALL be 1 only in SCAN with s=15 (MSB_FIRST=1) or s=0 (MSB_FIRST=0).
REQ-024 In SCAN, in_ready SHALL equal ser_last AND ser_ready; there is no other acceptance path.
REQ-025 Last transfer with in_valid=1: load the new word, reload s to the start value, stay in SCAN (back-to-back, zero bubble).
REQ-026 Last transfer with in_valid=0: go to IDLE; word and s hold their values.
REQ-027 Throughput SHALL be 1 bit/cycle with ser_ready held high; first ser_valid appears 1 cycle after acceptance.
REQ-028 A word SHALL take exactly 16 transfers; no word SHALL be truncated or extended.
REQ-029 in_data SHALL be sampled only on an accepting edge; changes at other times have no effect.

Reset
REQ-030 rst=1 at an edge SHALL force: state=IDLE, word=16'h0000, s=start value, ser_valid=0, ser_last=0, in_ready=1 (after the edge).
REQ-031 rst SHALL take priority over all handshakes; a word in progress is discarded and the reset-cycle in_valid is ignored.
REQ-032 The first acceptance SHALL be possible on the first edge with rst=0.

Verification
REQ-033 MSB_FIRST=1, in_data=16'h300E, ser_ready=1 -> ser_bit over 16 cycles = 0011_0000_0000_1110, s=0..15, ser_last only at s=15.
REQ-034 MSB_FIRST=0, in_data=16'h300E -> bits 0111_0000_0000_1100, s=15..0, ser_last at s=0.
REQ-035 Words 16'hA5A5 then 16'hFFFF presented back-to-back, ser_ready=1 -> 32 consecutive valid bits, no gap; in_ready high only on the 16th bit.
REQ-036 ser_ready=0 for 3 cycles at s=5 -> s, ser_bit and ser_valid frozen for 3 cycles; sequence resumes at s=5 with no skip.
REQ-037 rst asserted at s=8 mid-word -> next cycle IDLE, ser_valid=0, s=0, word=0; a new word scans from s=0.
REQ-038 Connect word and s to the 16:1 mux; for random words, the mux output SHALL equal ser_bit on every ser_valid cycle.
